// File: rtl/uart_rx_fifo_if.sv
// Receive-side stream between the UART receiver FIFO and its consumer:
// head word, non-empty flag and consumer acceptance.
interface uart_rx_fifo_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver (start + WIDTH data LSB first + optional parity + stop) feeding a DEPTH-entry FIFO.
// Optional parity bit compiled in with macro UART_RX_FIFO_PARITY_EN.
module uart_rx_fifo #(
    parameter int WIDTH      = 8,
    parameter int CLKDIV     = 16,
    parameter int DEPTH      = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx,
    uart_rx_fifo_if.master stream,
    output logic           frame_err,
    output logic           parity_err,
    output logic           overrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(CLKDIV);
    localparam int BW = $clog2(WIDTH);

    localparam logic [TW-1:0] TICK_FULL = TW'(CLKDIV - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(CLKDIV / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);

`ifdef UART_RX_FIFO_PARITY_EN
    localparam logic ODD = (PARITY_ODD != 0);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

    logic             rx_meta;
    logic             rs;
    state_t           state;
    logic [TW-1:0]    tick;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic             sample;
    logic             commit;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             empty;
    logic             pop;
    logic             push;

    // Two-flop synchroniser; idle level is high so reset to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rs      <= 1'b1;
        end else begin
            rx_meta <= rx;
            rs      <= rx_meta;
        end
    end

    assign sample = (tick == '0);

`ifdef UART_RX_FIFO_PARITY_EN
    logic bad;
    assign commit = (state == STOP) && sample && rs && !bad;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
    assign commit     = (state == STOP) && sample && rs;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tick      <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_FIFO_PARITY_EN
            bad        <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= commit && full && !pop;
`ifdef UART_RX_FIFO_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rs) begin
                        state   <= START;
                        tick    <= TICK_HALF;
                        bit_cnt <= '0;
`ifdef UART_RX_FIFO_PARITY_EN
                        bad     <= 1'b0;
`endif
                    end
                end
                START: begin
                    if (sample) begin
                        // A start bit that is high again at its centre was a glitch.
                        if (!rs) begin
                            state <= DATA;
                            tick  <= TICK_FULL;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        tick <= tick - 1'b1;
                    end
                end
                DATA: begin
                    if (sample) begin
                        shreg   <= {rs, shreg[WIDTH-1:1]};
                        tick    <= TICK_FULL;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_FIFO_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        tick <= tick - 1'b1;
                    end
                end
`ifdef UART_RX_FIFO_PARITY_EN
                PARITY: begin
                    if (sample) begin
                        bad   <= (rs != ((^shreg) ^ ODD));
                        tick  <= TICK_FULL;
                        state <= STOP;
                    end else begin
                        tick <= tick - 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (sample) begin
                        frame_err <= !rs;
`ifdef UART_RX_FIFO_PARITY_EN
                        parity_err <= bad;
`endif
                        state <= rs ? IDLE : WAIT_IDLE;
                    end else begin
                        tick <= tick - 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    // A held-low line (break) must return high before a new frame can start.
                    if (rs) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && stream.ready;
    assign push  = commit && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: the head word is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= shreg;
        end
    end

    assign stream.valid = !empty;
    assign stream.data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule
